// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction loader.
// Holds the FSM state encoding and the word-count legality helper.
package inst_loader_pkg;

   localparam int DEFAULT_DEPTH_LOG2 = 6;
   localparam int MAX_WORDS          = 2**DEFAULT_DEPTH_LOG2;
   localparam int BYTES_PER_WORD     = 4;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      WRITE,
      DONE
   } state_t;

   // A load must request between 1 and 2^depth_log2 words.
   function automatic logic count_ok(input int n, input int depth_log2);
      return (n >= 1) && (n <= (1 << depth_log2));
   endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-RAM write port of the loader.
// The master modport is the loader side.
interface inst_loader_if #(
   parameter int ADDR_W = 32
);
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;

   modport master (
      input  byte_in, byte_valid,
      output byte_ready, we, waddr, wdata
   );

   modport slave (
      output byte_in, byte_valid,
      input  byte_ready, we, waddr, wdata
   );
endinterface

// File: rtl/inst_loader_byte_packer.sv
// Collects the first three bytes of a big-endian word; the fourth byte is
// combined on the fly so the complete word is available on the 4th push.
module byte_packer
   import inst_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        push,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        full
);

   localparam int LANES = BYTES_PER_WORD - 1;

   logic [7:0] lane_reg [LANES];
   logic [1:0] cnt_reg;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               lane_reg[gi] <= 8'h00;
            end else if (clear) begin
               lane_reg[gi] <= 8'h00;
            end else if (push) begin
               if (gi == 0) begin
                  lane_reg[gi] <= byte_in;
               end else begin
                  lane_reg[gi] <= lane_reg[(gi == 0) ? 0 : gi - 1];
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= 2'd0;
      end else if (clear) begin
         cnt_reg <= 2'd0;
      end else if (push) begin
         cnt_reg <= cnt_reg + 2'd1;
      end
   end

   // Oldest byte sits in the highest lane and lands in bits [31:24].
   assign word = {lane_reg[2], lane_reg[1], lane_reg[0], byte_in};
   assign full = push && (cnt_reg == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Loads a program image from a byte stream into instruction RAM,
// one big-endian word at a time, holding the CPU while it does so.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
   parameter int ADDR_W     = 32
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [DEPTH_LOG2:0] num_words,
   input  logic                abort,
   inst_loader_if.master       bus,
   output logic                cpu_hold,
   output logic                busy,
   output logic                done,
   output logic                err
);

   state_t                  state_reg;
   logic [DEPTH_LOG2:0]     num_reg;
   logic [DEPTH_LOG2-1:0]   word_idx_reg;
   logic                    byte_ready_reg;
   logic                    we_reg;
   logic [ADDR_W-1:0]       waddr_reg;
   logic [31:0]             wdata_reg;
   logic                    cpu_hold_reg;
   logic                    busy_reg;
   logic                    done_reg;
   logic                    err_reg;

   logic                    pk_clear;
   logic                    pk_push;
   logic [31:0]             pk_word;
   logic                    pk_full;
   logic                    last_word;

   // Abort clears the packer so a 4th byte arriving with abort is dropped.
   assign pk_clear  = (state_reg != RECV) || abort;
   assign pk_push   = bus.byte_valid && byte_ready_reg;
   assign last_word = ({1'b0, word_idx_reg} + 1'b1) == num_reg;

   byte_packer u_packer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (pk_clear),
      .push    (pk_push),
      .byte_in (bus.byte_in),
      .word    (pk_word),
      .full    (pk_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         num_reg        <= '0;
         word_idx_reg   <= '0;
         byte_ready_reg <= 1'b0;
         we_reg         <= 1'b0;
         waddr_reg      <= '0;
         wdata_reg      <= '0;
         cpu_hold_reg   <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         we_reg   <= 1'b0;
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (count_ok(int'(num_words), DEPTH_LOG2)) begin
                     state_reg      <= RECV;
                     num_reg        <= num_words;
                     word_idx_reg   <= '0;
                     byte_ready_reg <= 1'b1;
                     cpu_hold_reg   <= 1'b1;
                     busy_reg       <= 1'b1;
                  end else begin
                     err_reg <= 1'b1;
                  end
               end
            end
            RECV: begin
               if (abort) begin
                  state_reg      <= IDLE;
                  byte_ready_reg <= 1'b0;
                  cpu_hold_reg   <= 1'b0;
                  busy_reg       <= 1'b0;
               end else if (pk_full) begin
                  state_reg      <= WRITE;
                  byte_ready_reg <= 1'b0;
                  we_reg         <= 1'b1;
                  waddr_reg      <= ADDR_W'({word_idx_reg, 2'b00});
                  wdata_reg      <= pk_word;
               end
            end
            WRITE: begin
               if (abort) begin
                  state_reg    <= IDLE;
                  cpu_hold_reg <= 1'b0;
                  busy_reg     <= 1'b0;
               end else if (last_word) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end else begin
                  state_reg      <= RECV;
                  word_idx_reg   <= word_idx_reg + 1'b1;
                  byte_ready_reg <= 1'b1;
               end
            end
            DONE: begin
               state_reg    <= IDLE;
               cpu_hold_reg <= 1'b0;
               busy_reg     <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.byte_ready = byte_ready_reg;
   assign bus.we         = we_reg;
   assign bus.waddr      = waddr_reg;
   assign bus.wdata      = wdata_reg;
   assign cpu_hold       = cpu_hold_reg;
   assign busy           = busy_reg;
   assign done           = done_reg;
   assign err            = err_reg;

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction-memory interface: receives a byte stream and assembles big-endian 32-bit instruction words.
- Writes each word into a writable instruction RAM at consecutive word-aligned byte addresses starting at 0; RAM indexes words by waddr[7:2].
- Holds the CPU pipeline stalled (cpu_hold) while a program image is being loaded.

Parameters:
- DEPTH_LOG2, 6, log2 of instruction RAM depth in words (64 words).
- ADDR_W, 32, width of waddr (byte address, same format as the PC).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle load request; sampled only in IDLE.
- num_words  in  DEPTH_LOG2+1  words to load, legal 1..2^DEPTH_LOG2; sampled with start.
- abort  in  1  cancels an in-progress load.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- we  out  1  RAM write strobe, one cycle per word.
- waddr  out  ADDR_W  byte address of the word, {word_idx,2'b00}, upper bits 0.
- wdata  out  32  assembled word.
- cpu_hold  out  1  stalls fetch/PC while high.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on an illegal num_words.

Behaviour:
- Reset (async, rst_n=0): state IDLE; byte_ready, we, cpu_hold, busy, done, err = 0; waddr, wdata = 0; byte counter and word index = 0; any partial word is discarded.
- States: IDLE, RECV, WRITE, DONE.
- IDLE, start=1, num_words in 1..64 -> RECV next cycle. Latch num_words, clear word_idx and byte count.
- IDLE, start=1, num_words=0 or >64 -> err=1 for the next cycle; stay in IDLE.
- start while not IDLE is ignored.
- RECV:
  - byte_ready=1.
  - A byte is accepted when byte_valid && byte_ready.
  - First accepted byte -> wdata[31:24], second -> [23:16], third -> [15:8], fourth -> [7:0].
  - On acceptance of the 4th byte -> WRITE next cycle.
- WRITE (exactly one cycle):
  - byte_ready=0; we=1; waddr={word_idx,2'b00}; wdata = complete word.
  - Next state: DONE if word_idx+1 == latched num_words; otherwise RECV, with word_idx incremented and byte count cleared.
- DONE (one cycle): done=1, cpu_hold still 1 -> IDLE next cycle.
- cpu_hold=1 in RECV, WRITE and DONE; 0 in IDLE.
- Minimum cost is 5 cycles per word (4 RECV + 1 WRITE).
- Throughput: byte_valid may stay high continuously; the loader stalls the source only during WRITE and DONE.
- abort=1 in RECV or WRITE:
  - -> IDLE next cycle; a WRITE in progress in that same cycle still completes.
  - Partial word discarded; done not pulsed; cpu_hold drops in IDLE.
- abort in IDLE or DONE has no effect.
- Abort has priority over the RECV->WRITE transition: the 4th byte accepted in the abort cycle is dropped.
- word_idx never exceeds 2^DEPTH_LOG2-1, so waddr never wraps. A 64-word load ends with waddr=0xFC.
- we is never asserted outside WRITE; wdata holds its last value when we=0.

Decomposition:
- Package inst_loader_pkg: state enum (IDLE, RECV, WRITE, DONE), MAX_WORDS = 2**DEPTH_LOG2, BYTES_PER_WORD = 4.
- Sub-module byte_packer: 4-byte shift register with 2-bit byte counter.
  - Inputs: clk, rst_n, clear, push, byte_in.
  - Outputs: word[31:0], full (4th push).
  - inst_loader owns the FSM, word index and RAM port.

Test Plan:
- Reset mid-load (rst_n low after 2 bytes of word 1) -> all outputs 0 immediately; the next load starting with start, num_words=1 writes a clean word with no stale bytes.
- start, num_words=2, bytes 00 10 14 64 28 00 38 26 with byte_valid held high:
  - we at waddr=0x0 with wdata=0x00101464, then we at waddr=0x4 with wdata=0x28003826.
  - done pulses once; cpu_hold is high from the cycle after start through the DONE cycle.
- Same load with byte_valid toggled every other cycle -> identical writes and data; byte_ready=0 during each WRITE cycle.
- start with num_words=0, then with num_words=65 -> err pulses once each; state stays IDLE; no we; busy stays 0.
- num_words=64 with incrementing words -> 64 writes, the last at waddr=0xFC; done pulses.
- abort after 6 bytes of a 3-word load -> exactly one we (word 0); no done; IDLE and cpu_hold=0 the next cycle; start is accepted afterwards.
